approx_mult_seq: RTL and testbench
==================================

APPROX_MULT_SEQ -- requirements
Module: approx_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; even, >= 4.
REQ-002 SHALL have parameter APPROX_DIAG, default 2; tile (i,j) is approximate when i+j < APPROX_DIAG.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands and mode valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port a  input  WIDTH  multiplicand, unsigned.
REQ-008 SHALL have port b  input  WIDTH  multiplier, unsigned.
REQ-009 SHALL have port precise_en  input  1  1 = exact product, 0 = approximate.
REQ-010 SHALL have port out_valid  output  1  y holds a completed result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts y.
REQ-012 SHALL have port y  output  2*WIDTH  product.

Function
REQ-013 SHALL define tiles: a digit i = a[2i+1:2i], b digit j = b[2j+1:2j], i,j in 0..WIDTH/2-1, weight 4^(i+j).
REQ-014 SHALL use exact 2x2 tile product when precise_en=1 or i+j >= APPROX_DIAG.
REQ-015 SHALL use approximate tile product otherwise: identical to exact except 3x3 = 7 (not 9).
REQ-016 SHALL form y as exact, carry-complete sum of all weighted tile products, no truncation, 2*WIDTH bits.
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-018 SHALL assert in_ready only in IDLE; transfer occurs when in_valid && in_ready at a rising edge.
REQ-019 SHALL on transfer latch a, b, precise_en, clear accumulator and digit counter k, enter RUN.
REQ-020 SHALL in each RUN cycle add sum over i of tile(i,k)*4^(i+k), then increment k.
REQ-021 SHALL leave RUN after exactly WIDTH/2 RUN cycles (k = WIDTH/2-1 processed), entering DONE.
REQ-022 SHALL assert out_valid in DONE only; out_valid rises WIDTH/2+1 edges after the transfer edge (5 for WIDTH=8).
REQ-023 SHALL hold y and out_valid stable in DONE until out_valid && out_ready at an edge, then return to IDLE.
REQ-024 SHALL NOT accept a new operation in the same cycle as result handoff; next transfer earliest one cycle later.
REQ-025 SHALL ignore changes to a, b, precise_en, in_valid while in RUN or DONE.
REQ-026 SHALL produce y = 0 for a = 0 or b = 0 in either mode.

Reset
REQ-027 SHALL on rst=1 at any edge, including mid-RUN or DONE, enter IDLE, abandoning any operation.
REQ-028 SHALL reset values: in_ready=1 in the cycle after reset, out_valid=0, y=0, k=0, accumulator=0.
REQ-029 SHALL ignore in_valid in any cycle where rst=1.

Configuration
REQ-030 SHALL, with macro APPROX_MULT_ERR_CNT_EN defined, add output err_cnt (16 bits) and compute the exact product alongside.
REQ-031 SHALL increment err_cnt, saturating at 0xFFFF, at each result handoff whose y differs from the exact product; reset to 0.
REQ-032 SHALL, with APPROX_MULT_ERR_CNT_EN undefined, omit err_cnt and all exact-shadow logic; y behaviour unchanged.

Verification
REQ-033 SHALL cover WIDTH=8, a=3, b=3, precise_en=0 -> y=7; precise_en=1 -> y=9.
REQ-034 SHALL cover a=255, b=255: precise_en=1 -> y=65025; precise_en=0 -> y=65007.
REQ-035 SHALL cover transfer at edge 0 -> out_valid first high after edge 5; with out_ready=0 for 10 cycles -> y and out_valid stable.
REQ-036 SHALL cover rst=1 during RUN (third cycle) -> next cycle in_ready=1, out_valid=0, y=0, and no stale result later.
REQ-037 SHALL cover in_valid held high with new operands during RUN -> operands ignored, result matches first operation.
REQ-038 SHALL cover, with APPROX_MULT_ERR_CNT_EN, 3x3 approx then 3x3 precise -> err_cnt=1 after both handoffs.

Source files
------------

// File: rtl/approx_mult_seq.sv
// -----------------------------------------------------------------------------
// approx_mult_seq
//
// Sequential radix-4 (2-bit digit) unsigned multiplier with a selectable
// approximate mode. Operands are split into 2-bit digits; each digit pair
// forms a 2x2 "tile" product weighted by 4^(i+j). In approximate mode the
// low-significance tiles (i+j < APPROX_DIAG) use a cheaper 2x2 multiplier
// whose only difference is 3x3 = 7. One multiplier digit (one row of tiles)
// is accumulated per RUN cycle, so a result takes WIDTH/2 RUN cycles.
//
// Handshake: valid/ready on both sides. in_ready is high only in IDLE;
// out_valid is high only in DONE and holds y stable until out_ready.
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    operands / mode valid
//   in_ready    block can accept an operation (IDLE only)
//   a, b        unsigned multiplicand / multiplier, WIDTH bits
//   precise_en  1 = exact product, 0 = approximate product
//   out_valid   y holds a completed result
//   out_ready   consumer accepts y
//   y           product, 2*WIDTH bits
//   err_cnt     (only with APPROX_MULT_ERR_CNT_EN) saturating count of
//               handed-off results that differed from the exact product
//
// Optional feature macro: APPROX_MULT_ERR_CNT_EN
// -----------------------------------------------------------------------------
module approx_mult_seq #(
  parameter int WIDTH       = 8,
  parameter int APPROX_DIAG = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 precise_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y
`ifdef APPROX_MULT_ERR_CNT_EN
  ,
  output logic [15:0]          err_cnt
`endif
);

  localparam int ND = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam int KW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ND - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // 2x2 digit product; the approximate variant maps 3x3 to 7 instead of 9.
  function automatic logic [3:0] tile_prod(input logic [1:0] da,
                                           input logic [1:0] db,
                                           input logic       approx);
    logic [3:0] p;
    if (approx && (da == 2'd3) && (db == 2'd3)) begin
      p = 4'd7;
    end else begin
      p = {2'b00, da} * {2'b00, db};
    end
    return p;
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             prec_q;
  logic [KW-1:0]    k_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    row_s;
  logic [PW-1:0]    y_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // Weighted sum of the tile row selected by multiplier digit k.
  always_comb begin
    row_s = '0;
    for (int i = 0; i < ND; i++) begin
      row_s = row_s
            + (PW'(tile_prod(a_q[2*i +: 2], b_q[2*int'(k_q) +: 2],
                             (!prec_q) && ((i + int'(k_q)) < APPROX_DIAG)))
               << (2 * (i + int'(k_q))));
    end
  end

  // Next accumulator value for the current RUN cycle.
  always_comb begin
    acc_d = acc_q + row_s;
  end

`ifdef APPROX_MULT_ERR_CNT_EN
  logic [PW-1:0] ex_acc_q;
  logic [PW-1:0] ex_acc_d;
  logic [PW-1:0] ex_row_s;
  logic [PW-1:0] ex_y_q;
  logic [15:0]   err_cnt_q;

  // Exact shadow row: same digit selection with approximation disabled.
  always_comb begin
    ex_row_s = '0;
    for (int i = 0; i < ND; i++) begin
      ex_row_s = ex_row_s
               + (PW'(tile_prod(a_q[2*i +: 2], b_q[2*int'(k_q) +: 2], 1'b0))
                  << (2 * (i + int'(k_q))));
    end
  end

  // Next exact-shadow accumulator value.
  always_comb begin
    ex_acc_d = ex_acc_q + ex_row_s;
  end

  // Exact shadow accumulation and saturating mismatch counter at handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_acc_q  <= '0;
      ex_y_q    <= '0;
      err_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            ex_acc_q <= '0;
          end else begin
            ex_acc_q <= ex_acc_q;
          end
        end
        S_RUN: begin
          ex_acc_q <= ex_acc_d;
        end
        S_DONE: begin
          if (!out_valid_q) begin
            ex_y_q <= ex_acc_q;
          end else if (out_ready && (y_q != ex_y_q) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
          end else begin
            err_cnt_q <= err_cnt_q;
          end
        end
        default: begin
          ex_acc_q <= '0;
        end
      endcase
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  // Control FSM with registered handshake outputs and result register.
  // DONE spends one cycle loading y before raising out_valid, so the
  // result appears WIDTH/2+1 edges after the transfer edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      prec_q      <= 1'b0;
      k_q         <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            prec_q     <= precise_en;
            acc_q      <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          if (k_q == K_LAST) begin
            k_q     <= '0;
            state_q <= S_DONE;
          end else begin
            k_q     <= k_q + KW'(1);
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          if (!out_valid_q) begin
            y_q         <= acc_q;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            // Handoff: in_ready only rises after this edge, so no new
            // operation can be accepted in the handoff cycle itself.
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_approx_mult_seq.sv
module tb_approx_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        precise_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
`ifdef APPROX_MULT_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];

  approx_mult_seq #(.WIDTH(8), .APPROX_DIAG(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .precise_en (precise_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y)
`ifdef APPROX_MULT_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference: sum of weighted 2x2 digit products, approximate 3x3=7 on low tiles.
  function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] bv, input bit p);
    int s;
    int da;
    int db;
    int t;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        da = (av >> (2*i)) & 3;
        db = (bv >> (2*j)) & 3;
        t  = da * db;
        if (!p && (i + j) < 2 && da == 3 && db == 3) t = 7;
        s = s + (t << (2*(i+j)));
      end
    end
    return s[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; in_valid = 1'b0; a = 8'd0; b = 8'd0; precise_en = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    sb.delete();
  endtask

  // Waits for in_ready, performs one transfer, pushes the expected result.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input bit p, output bit ok);
    ok = 1'b0;
    a = av; b = bv; precise_en = p; in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    if (ok) sb.push_back(model(av, bv, p));
  endtask

  // Waits for out_valid; lat = edges waited. Completes the handoff if out_ready.
  task automatic collect(output logic [15:0] yv, output int lat, output bit ok);
    ok = 1'b0; lat = 0; yv = 16'd0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (out_valid) begin
        ok = 1'b1; lat = n; yv = y;
        break;
      end
    end
    if (ok && out_ready) tick();
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (y !== 16'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", y); end
`ifdef APPROX_MULT_ERR_CNT_EN
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
`endif
  endtask

  task automatic test_corner_products();
    logic [7:0]  ta[6] = '{8'd3, 8'd3, 8'd255, 8'd255, 8'd0, 8'd201};
    logic [7:0]  tb_[6] = '{8'd3, 8'd3, 8'd255, 8'd255, 8'd173, 8'd0};
    bit          tp[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] te[6] = '{16'd7, 16'd9, 16'd65025, 16'd65007, 16'd0, 16'd0};
    logic [15:0] yv;
    logic [15:0] exp;
    int lat;
    bit ok;
    for (int t = 0; t < 6; t++) begin
      send(ta[t], tb_[t], tp[t], ok);
      collect(yv, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL corner_timeout[%0d] got=none exp=out_valid", t); end
      checks++; if (yv !== te[t]) begin errors++; $display("FAIL corner_y[%0d] a=%0d b=%0d p=%0d got=%0d exp=%0d", t, ta[t], tb_[t], tp[t], yv, te[t]); end
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        checks++; if (yv !== exp) begin errors++; $display("FAIL corner_sb[%0d] got=%0d exp=%0d", t, yv, exp); end
      end
    end
  endtask

  task automatic test_latency_stall();
    logic [15:0] yv;
    logic [15:0] exp;
    int lat;
    bit ok;
    bit stable;
    out_ready = 1'b0;
    send(8'd3, 8'd3, 1'b1, ok);
    collect(yv, lat, ok);
    checks++; if (lat !== 5) begin errors++; $display("FAIL latency got=%0d exp=5", lat); end
    stable = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (out_valid !== 1'b1 || y !== yv) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stall_stable got=%b exp=1", stable); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL handoff_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL handoff_in_ready got=%b exp=1", in_ready); end
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      checks++; if (yv !== exp) begin errors++; $display("FAIL stall_y got=%0d exp=%0d", yv, exp); end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    bit seen;
    send(8'd200, 8'd150, 1'b1, ok);
    tick(); tick();
    rst = 1'b1; in_valid = 1'b1; a = 8'd77; b = 8'd99; precise_en = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    if (ok) void'(sb.pop_back());
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (y !== 16'd0) begin errors++; $display("FAIL midrst_y got=%0d exp=0", y); end
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_stale got=%b exp=0", seen); end
  endtask

  task automatic test_ignore_during_run();
    logic [15:0] yv;
    logic [15:0] exp;
    int lat;
    bit ok;
    bit seen;
    send(8'h5A, 8'hC3, 1'b0, ok);
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; precise_en = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    collect(yv, lat, ok);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      checks++; if (yv !== exp) begin errors++; $display("FAIL ignore_y got=%0d exp=%0d", yv, exp); end
    end
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ignore_extra_result got=%b exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] yv;
    logic [15:0] exp;
    int lat;
    bit ok;
    int bad;
    bad = 0;
    for (int t = 0; t < 24; t++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), ok);
      collect(yv, lat, ok);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        checks++; if (yv !== exp || lat !== 5) begin
          errors++; bad++;
          $display("FAIL random_op[%0d] got=%0d lat=%0d exp=%0d lat=5", t, yv, lat, exp);
        end
      end
    end
  endtask

`ifdef APPROX_MULT_ERR_CNT_EN
  task automatic test_err_cnt();
    logic [15:0] yv;
    int lat;
    bit ok;
    reset_dut();
    send(8'd3, 8'd3, 1'b0, ok);
    collect(yv, lat, ok);
    send(8'd3, 8'd3, 1'b1, ok);
    collect(yv, lat, ok);
    tick();
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL err_cnt got=%0d exp=1", err_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 8'd0; b = 8'd0; precise_en = 1'b0; out_ready = 1'b1;
    test_reset();
    test_corner_products();
    test_latency_stall();
    test_reset_mid_run();
    test_ignore_during_run();
    test_back_to_back();
`ifdef APPROX_MULT_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
